// File: rtl/free_list_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | free_list_pkg : sizing constants and helpers for the rename free list     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package free_list_pkg;

  localparam int PHY_REG_SEL   = 6;
  localparam int NUM_PHY_REGS  = 2 ** PHY_REG_SEL;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_INIT_FREE = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int IDX_W         = PHY_REG_SEL;
  localparam int PTR_W         = PHY_REG_SEL + 1;

  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | free_list : 2-wide physical register free list with flush rewind          |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module free_list
  import free_list_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_req_1,
  input  logic                   alloc_req_2,
  output logic [PHY_REG_SEL-1:0] phy_dst_1_from_free_list,
  output logic [PHY_REG_SEL-1:0] phy_dst_2_from_free_list,
  output logic                   alloc_stall,
  input  logic                   free_valid_1,
  input  logic                   free_valid_2,
  input  logic [PHY_REG_SEL-1:0] free_reg_1,
  input  logic [PHY_REG_SEL-1:0] free_reg_2,
  input  logic                   commit_alloc_1,
  input  logic                   commit_alloc_2,
  input  logic                   flush,
  output logic [PHY_REG_SEL:0]   free_count
);

  logic [IDX_W-1:0] r_entries [NUM_PHY_REGS];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_retire_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_free_count;

  logic [1:0]       w_nreq;
  logic [1:0]       w_nfree;
  logic [1:0]       w_ncommit;
  logic             w_stall;
  logic [IDX_W-1:0] w_rd_idx_0;
  logic [IDX_W-1:0] w_rd_idx_1;
  logic [IDX_W-1:0] w_wr_idx_1;
  logic [IDX_W-1:0] w_wr_idx_2;
  logic [IDX_W-1:0] w_peek_0;
  logic [IDX_W-1:0] w_peek_1;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_retire_nxt;
  logic [PTR_W-1:0] w_tail_nxt;

  assign w_nreq    = count2(alloc_req_1, alloc_req_2);
  assign w_nfree   = count2(free_valid_1, free_valid_2);
  assign w_ncommit = count2(commit_alloc_1, commit_alloc_2);

  // Stall looks only at registered occupancy, so same-cycle frees never help.
  assign w_stall = PTR_W'(w_nreq) > r_free_count;

  assign w_rd_idx_0 = r_head[IDX_W-1:0];
  assign w_rd_idx_1 = w_rd_idx_0 + IDX_W'(1);
  assign w_peek_0   = r_entries[w_rd_idx_0];
  assign w_peek_1   = r_entries[w_rd_idx_1];

  assign w_wr_idx_1 = r_tail[IDX_W-1:0];
  assign w_wr_idx_2 = r_tail[IDX_W-1:0] + IDX_W'(free_valid_1);

  // A lone slot-2 request takes the oldest free tag.
  assign phy_dst_1_from_free_list = w_peek_0;
  assign phy_dst_2_from_free_list = (alloc_req_2 && !alloc_req_1) ? w_peek_0 : w_peek_1;
  assign alloc_stall              = w_stall;
  assign free_count               = r_free_count;

  always_comb begin
    w_retire_nxt = r_retire_head + PTR_W'(w_ncommit);
    w_tail_nxt   = r_tail + PTR_W'(w_nfree);
    w_head_nxt   = r_head;
    if (flush) begin
      w_head_nxt = w_retire_nxt;
    end else if (!w_stall) begin
      w_head_nxt = r_head + PTR_W'(w_nreq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHY_REGS; i++) begin
        r_entries[i] <= (i < NUM_INIT_FREE) ? IDX_W'(NUM_ARCH_REGS + i) : '0;
      end
      r_head        <= '0;
      r_retire_head <= '0;
      r_tail        <= PTR_W'(NUM_INIT_FREE);
      r_free_count  <= PTR_W'(NUM_INIT_FREE);
    end else begin
      if (free_valid_1) begin
        r_entries[w_wr_idx_1] <= free_reg_1;
      end
      if (free_valid_2) begin
        r_entries[w_wr_idx_2] <= free_reg_2;
      end
      r_head        <= w_head_nxt;
      r_retire_head <= w_retire_nxt;
      r_tail        <= w_tail_nxt;
      r_free_count  <= w_tail_nxt - w_head_nxt;
    end
  end

  logic [PTR_W-1:0] w_in_flight;
  logic [PTR_W-1:0] w_retire_span;
  assign w_in_flight   = r_head - r_retire_head;
  assign w_retire_span = r_tail - r_retire_head;

  a_free_bound: assert property (@(posedge clk) disable iff (reset)
    int'(r_free_count) <= NUM_INIT_FREE + int'(w_in_flight));
  a_retire_order: assert property (@(posedge clk) disable iff (reset)
    int'(w_in_flight) <= NUM_PHY_REGS);
  a_tail_span: assert property (@(posedge clk) disable iff (reset)
    int'(w_retire_span) <= NUM_PHY_REGS);

endmodule
`default_nettype wire
